// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined logarithmic shifter with valid/ready flow control.
//
// One stage per shift-amount bit. Stage k shifts by 2^k when bit k of the
// request's shift amount is set, otherwise it passes the data through.
// Each stage register holds valid, data, op and the shift amount. The
// last stage register drives the output interface directly.
//
// Ports
//   clock      in   single clock, all state on the rising edge
//   resetn     in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  request accepted on in_valid && in_ready
//   in_data    in   operand, WIDTH bits
//   in_shamt   in   shift amount, SHW bits
//   in_op      in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  out  result present
//   out_ready  in   result consumed on out_valid && out_ready
//   out_data   out  shifted result
//   out_zero   out  out_data == 0
//   occupancy  out  number of valid stage registers, 0..SHW
module shifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [SHW:0]     occupancy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage registers
  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [1:0]       op_q    [SHW];
  logic [1:0]       op_d    [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic [SHW:0]     occ_q, occ_d;

  // adv[k]: stage k loads new contents (from upstream) at the next edge.
  logic [SHW-1:0]   adv;

  logic             accept;
  logic             drain;

  // Fixed-distance shift; amt is always a constant power of two per stage,
  // so each call unrolls to plain wiring plus a 4-way mux.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int unsigned      amt
  );
    logic signed [WIDTH-1:0] s;
    logic [WIDTH-1:0]        r;
    s = $signed(d);
    r = d;
    unique case (op)
      OP_SLL: r = d << amt;
      OP_SRL: r = d >> amt;
      OP_SRA: r = $unsigned(s >>> amt);
      OP_ROR: r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  // Ready chain, computed from the output back to the input. A stage may
  // take new contents when it is empty or its contents move downstream.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = !valid_q[SHW-1] || out_ready;
    adv[SHW-1] = nxt;
    for (int k = SHW - 2; k >= 0; k--) begin
      nxt = !valid_q[k] || nxt;
      adv[k] = nxt;
    end
  end

  assign accept = in_valid && adv[0];
  assign drain  = valid_q[SHW-1] && out_ready;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < SHW; k++) begin
      data_d[k]  = data_q[k];
      op_d[k]    = op_q[k];
      shamt_d[k] = shamt_q[k];
    end

    if (adv[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_shamt[0] ? shift_step(in_data, in_op, 1) : in_data;
      op_d[0]    = in_op;
      shamt_d[0] = in_shamt;
    end

    for (int k = 1; k < SHW; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = shamt_q[k-1][k]
                     ? shift_step(data_q[k-1], op_q[k-1], 1 << k)
                     : data_q[k-1];
        op_d[k]    = op_q[k-1];
        shamt_d[k] = shamt_q[k-1];
      end
    end

    // Accept and drain in the same cycle cancel out.
    occ_d = occ_q + (SHW+1)'(accept) - (SHW+1)'(drain);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        op_q[k]    <= '0;
        shamt_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        op_q[k]    <= op_d[k];
        shamt_q[k] <= shamt_d[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = (data_q[SHW-1] == '0);
  assign occupancy = occ_q;

endmodule
